// File: rtl/arith_pkg.sv
// Shared definitions for the sum-of-squares / multiplier datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_A = 2'd1,
        MUL_B = 2'd2,
        ADD   = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int PROD_W    = 2 * DEF_WIDTH;
    localparam int SUM_W     = 2 * DEF_WIDTH + 1;

    // Product width for a given operand width.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Width of the sum of two products; one extra bit so nothing is lost before saturation.
    function automatic int sum_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: the launch edge consumes bit 0, WIDTH-1 more edges; product valid WIDTH cycles after launch.
// Backpressure: start_i is ignored while busy_o is high; product holds until the next launch.
module mul_shift_add
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    output logic                 busy_o,
    output logic [2*WIDTH-1:0]   y_bo
);

    localparam int PW = prod_w(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic              busy_q,   busy_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [PW-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q,    acc_d;

    // Launch folds bit 0 into the load so the whole product takes exactly WIDTH edges.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (!busy_q && start_i) begin
            acc_d    = b_bi[0] ? PW'(a_bi) : '0;
            mcand_d  = PW'(a_bi) << 1;
            mplier_d = b_bi >> 1;
            cnt_d    = CW'(1);
            busy_d   = (WIDTH > 1);
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Multiplier state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = acc_q;

endmodule

// File: rtl/sum_sq.sv
// Sequential y = a*a + b*b, saturated to OUT_W bits, feeding the integer sqrt stage.
// Latency: busy_o high for 2*WIDTH+1 cycles; valid_o pulses in the first IDLE cycle after.
// Backpressure: start_i accepted only in IDLE; requests while busy are dropped, not queued.
module sum_sq
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OUT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    input  logic               start_i,
    output logic               busy_o,
    output logic [OUT_W-1:0]   y_bo,
    output logic               ovf_o,
    output logic               valid_o
);

    localparam int PW = prod_w(WIDTH);
    localparam int SW = sum_w(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] SAT_MAX = SW'((64'd1 << OUT_W) - 64'd1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  b_q,     b_d;
    logic [PW-1:0]     p_a_q,   p_a_d;
    logic [PW-1:0]     p_b_q,   p_b_d;
    logic [OUT_W-1:0]  y_q,     y_d;
    logic              ovf_q,   ovf_d;
    logic              busy_q,  busy_d;
    logic              valid_q, valid_d;

    logic              mul_start;
    logic              mul_busy;
    logic [WIDTH-1:0]  mul_op;
    logic [PW-1:0]     mul_y;
    logic              last_bit;
    logic [SW-1:0]     sum;

    // a is squared straight off the input on the launch edge, so the multiplier's own
    // operand registers are the latched copy of a; b is latched here for the second pass.
    assign last_bit  = (cnt_q == CW'(WIDTH - 1)) && !mul_busy;
    assign mul_op    = (state_q == IDLE) ? a_bi : b_q;
    assign mul_start = ((state_q == IDLE) && start_i) || ((state_q == MUL_A) && last_bit);
    assign sum       = SW'(p_a_q) + SW'(p_b_q);

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_bi    (mul_op),
        .b_bi    (mul_op),
        .busy_o  (mul_busy),
        .y_bo    (mul_y)
    );

    // Next-state and datapath updates for the top sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        p_a_d   = p_a_q;
        p_b_d   = p_b_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    b_d     = b_bi;
                    p_a_d   = '0;
                    p_b_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MUL_A;
                end
            end
            MUL_A: begin
                if (last_bit) begin
                    p_a_d   = mul_y;
                    cnt_d   = '0;
                    state_d = MUL_B;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MUL_B: begin
                if (last_bit) begin
                    p_b_d   = mul_y;
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ADD: begin
                if (sum > SAT_MAX) begin
                    y_d   = '1;
                    ovf_d = 1'b1;
                end else begin
                    y_d   = sum[OUT_W-1:0];
                    ovf_d = 1'b0;
                end
                busy_d  = 1'b0;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            p_a_q   <= '0;
            p_b_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            p_a_q   <= p_a_d;
            p_b_q   <= p_b_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = busy_q;
    assign y_bo    = y_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;

endmodule
